// File: rtl/lcd_nibble_writer_if.sv
// ----------------------------------------------------------------------------
// lcd_nibble_writer_if
//   Byte-write channel from the text/command sequencer into the LCD
//   nibble writer. A transfer happens on the clock edge where in_valid and
//   in_ready are both high.
// Signals
//   in_valid  master->slave  byte write request
//   in_ready  slave->master  writer can accept a byte this cycle
//   in_rs     master->slave  0 = command, 1 = character data
//   in_data   master->slave  byte to write
// ----------------------------------------------------------------------------
interface lcd_nibble_writer_if;
    logic       in_valid;
    logic       in_ready;
    logic       in_rs;
    logic [7:0] in_data;

    modport master (
        output in_valid,
        output in_rs,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_rs,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/lcd_nibble_writer.sv
// ----------------------------------------------------------------------------
// lcd_nibble_writer
//   Physical-interface stage for an HD44780-class character LCD in 4-bit
//   mode. Runs the 4-bit power-up sequence (0x3,0x3,0x3,0x2) on its own,
//   then accepts byte writes and sends each one high nibble first, with
//   programmable E setup, E high, inter-nibble gap and settle times.
// Ports
//   clk        clock
//   rst        asynchronous active-high reset
//   wr         byte-write channel (slave side): in_valid/in_ready/in_rs/in_data
//   init_done  power-up sequence complete, sticky until reset
//   busy       inverse of in_ready
//   lcd_rs     LCD RS pin
//   lcd_e      LCD E strobe (registered)
//   lcd_d      LCD D7..D4
// ----------------------------------------------------------------------------
module lcd_nibble_writer #(
    parameter int unsigned E_SETUP_CYC   = 2,
    parameter int unsigned E_HIGH_CYC    = 8,
    parameter int unsigned NIB_GAP_CYC   = 16,
    parameter int unsigned CMD_WAIT_CYC  = 64,
    parameter int unsigned LONG_WAIT_CYC = 2048,
    parameter int unsigned INIT_WAIT_CYC = 4096
) (
    input  logic                clk,
    input  logic                rst,
    lcd_nibble_writer_if.slave  wr,
    output logic                init_done,
    output logic                busy,
    output logic                lcd_rs,
    output logic                lcd_e,
    output logic [3:0]          lcd_d
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned MAX_CYC = max2(max2(max2(E_SETUP_CYC, E_HIGH_CYC),
                                                max2(NIB_GAP_CYC, CMD_WAIT_CYC)),
                                           max2(LONG_WAIT_CYC, INIT_WAIT_CYC));
    localparam int CW = $clog2(MAX_CYC) + 1;

    // The counter is loaded with (duration - 1) and the phase ends on the
    // edge where it is already zero, so each phase lasts exactly its duration.
    localparam logic [CW-1:0] LD_SETUP = CW'(E_SETUP_CYC - 1);
    localparam logic [CW-1:0] LD_HIGH  = CW'(E_HIGH_CYC - 1);
    localparam logic [CW-1:0] LD_GAP   = CW'(NIB_GAP_CYC - 1);
    localparam logic [CW-1:0] LD_CMD   = CW'(CMD_WAIT_CYC - 1);
    localparam logic [CW-1:0] LD_LONG  = CW'(LONG_WAIT_CYC - 1);
    localparam logic [CW-1:0] LD_INIT  = CW'(INIT_WAIT_CYC - 1);

    typedef enum logic [3:0] {
        PWR_WAIT,
        INIT_NIB,
        IDLE,
        SETUP_HI,
        PULSE_HI,
        GAP,
        SETUP_LO,
        PULSE_LO,
        SETTLE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            init_done_q, init_done_d;
    logic [1:0]      init_idx_q, init_idx_d;
    logic            rs_q, rs_d;
    logic [7:0]      data_q, data_d;
    logic            lcd_rs_q, lcd_rs_d;
    logic [3:0]      lcd_d_q, lcd_d_d;
    logic            lcd_e_q;

    logic            cnt_zero;
    logic            accept;
    logic            long_cmd;

    assign cnt_zero    = (cnt_q == '0);
    assign wr.in_ready = (state_q == IDLE) && init_done_q;
    assign accept      = wr.in_valid && wr.in_ready;

    // Clear display (0x01) and return home (0x02/0x03) need the long settle.
    assign long_cmd = !rs_q && (data_q[7:2] == 6'd0) && (data_q[1:0] != 2'd0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_zero ? cnt_q : cnt_q - CW'(1);
        init_done_d = init_done_q;
        init_idx_d  = init_idx_q;
        rs_d        = rs_q;
        data_d      = data_q;
        lcd_rs_d    = lcd_rs_q;
        lcd_d_d     = lcd_d_q;

        case (state_q)
            PWR_WAIT: begin
                if (cnt_zero) begin
                    state_d  = INIT_NIB;
                    cnt_d    = LD_SETUP;
                    lcd_rs_d = 1'b0;
                    lcd_d_d  = 4'h3;
                end
            end
            // Init nibbles reuse the low-nibble pulse and the settle phase.
            INIT_NIB: begin
                if (cnt_zero) begin
                    state_d = PULSE_LO;
                    cnt_d   = LD_HIGH;
                end
            end
            IDLE: begin
                if (accept) begin
                    state_d  = SETUP_HI;
                    cnt_d    = LD_SETUP;
                    rs_d     = wr.in_rs;
                    data_d   = wr.in_data;
                    lcd_rs_d = wr.in_rs;
                    lcd_d_d  = wr.in_data[7:4];
                end
            end
            SETUP_HI: begin
                if (cnt_zero) begin
                    state_d = PULSE_HI;
                    cnt_d   = LD_HIGH;
                end
            end
            PULSE_HI: begin
                if (cnt_zero) begin
                    state_d = GAP;
                    cnt_d   = LD_GAP;
                end
            end
            // Low nibble is presented only after the gap, so D never moves
            // in the cycle E falls.
            GAP: begin
                if (cnt_zero) begin
                    state_d = SETUP_LO;
                    cnt_d   = LD_SETUP;
                    lcd_d_d = data_q[3:0];
                end
            end
            SETUP_LO: begin
                if (cnt_zero) begin
                    state_d = PULSE_LO;
                    cnt_d   = LD_HIGH;
                end
            end
            PULSE_LO: begin
                if (cnt_zero) begin
                    state_d = SETTLE;
                    cnt_d   = (init_done_q && long_cmd) ? LD_LONG : LD_CMD;
                end
            end
            SETTLE: begin
                if (cnt_zero) begin
                    if (init_done_q) begin
                        state_d = IDLE;
                    end else if (init_idx_q == 2'd3) begin
                        state_d     = IDLE;
                        init_done_d = 1'b1;
                    end else begin
                        state_d    = INIT_NIB;
                        cnt_d      = LD_SETUP;
                        init_idx_d = init_idx_q + 2'd1;
                        // Sequence is 3,3,3,2: the last one follows index 2.
                        lcd_d_d    = (init_idx_q == 2'd2) ? 4'h2 : 4'h3;
                    end
                end
            end
            default: begin
                state_d = PWR_WAIT;
                cnt_d   = LD_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= PWR_WAIT;
            cnt_q       <= LD_INIT;
            init_done_q <= 1'b0;
            init_idx_q  <= 2'd0;
            rs_q        <= 1'b0;
            data_q      <= 8'h00;
            lcd_rs_q    <= 1'b0;
            lcd_d_q     <= 4'h0;
            lcd_e_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            init_idx_q  <= init_idx_d;
            rs_q        <= rs_d;
            data_q      <= data_d;
            lcd_rs_q    <= lcd_rs_d;
            lcd_d_q     <= lcd_d_d;
            lcd_e_q     <= (state_d == PULSE_HI) || (state_d == PULSE_LO);
        end
    end

    assign init_done = init_done_q;
    assign busy      = ~wr.in_ready;
    assign lcd_rs    = lcd_rs_q;
    assign lcd_d     = lcd_d_q;
    assign lcd_e     = lcd_e_q;

endmodule

// File: tb/tb_lcd_nibble_writer.sv
// ----------------------------------------------------------------------------
// tb_lcd_nibble_writer
//   Drives directed and random byte writes into lcd_nibble_writer and
//   compares the E-strobe nibble stream and handshake timing against a
//   queue-based reference built from the LCD write rules.
// ----------------------------------------------------------------------------
module tb_lcd_nibble_writer;

    localparam int SETUP = 2;
    localparam int HIGH  = 4;
    localparam int GAP   = 3;
    localparam int CMD   = 10;
    localparam int LONG  = 40;
    localparam int INIT  = 20;
    localparam int INIT_LAT = INIT + 4 * (SETUP + HIGH + CMD);

    logic       clk;
    logic       rst;
    logic       init_done;
    logic       busy;
    logic       lcd_rs;
    logic       lcd_e;
    logic [3:0] lcd_d;

    lcd_nibble_writer_if bus ();

    lcd_nibble_writer #(
        .E_SETUP_CYC   (SETUP),
        .E_HIGH_CYC    (HIGH),
        .NIB_GAP_CYC   (GAP),
        .CMD_WAIT_CYC  (CMD),
        .LONG_WAIT_CYC (LONG),
        .INIT_WAIT_CYC (INIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr        (bus),
        .init_done (init_done),
        .busy      (busy),
        .lcd_rs    (lcd_rs),
        .lcd_e     (lcd_e),
        .lcd_d     (lcd_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected E-strobe contents, {rs, d}, oldest first.
    logic [4:0] exp_q[$];

    function automatic int settle_of(input logic rs, input logic [7:0] d);
        return (!rs && d >= 8'd1 && d <= 8'd3) ? LONG : CMD;
    endfunction

    // Pulse monitor: checks contents on each rising E, and that RS/D are
    // stable before the rise, during the pulse and on the falling cycle.
    logic       e_prev;
    logic [4:0] nib_prev;
    logic [4:0] exp_nib;
    int         high_cnt;

    always @(negedge clk) begin
        if (rst) begin
            e_prev   = 1'b0;
            nib_prev = 5'd0;
            high_cnt = 0;
        end else begin
            if (lcd_e && !e_prev) begin
                check("setup_stable", {lcd_rs, lcd_d}, nib_prev);
                check("pulse_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    exp_nib = exp_q.pop_front();
                    check("nibble", {lcd_rs, lcd_d}, exp_nib);
                end
                high_cnt = 1;
            end else if (lcd_e) begin
                check("hold_high", {lcd_rs, lcd_d}, nib_prev);
                high_cnt++;
            end else if (e_prev) begin
                check("e_width", high_cnt, HIGH);
                check("hold_fall", {lcd_rs, lcd_d}, nib_prev);
            end
            e_prev   = lcd_e;
            nib_prev = {lcd_rs, lcd_d};
        end
    end

    task automatic check_reset_state();
        check("rst_lcd_e", lcd_e, 1'b0);
        check("rst_lcd_rs", lcd_rs, 1'b0);
        check("rst_lcd_d", lcd_d, 4'h0);
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_busy", busy, 1'b1);
        check("rst_init_done", init_done, 1'b0);
    endtask

    // Called on a negedge with rst high; releases it and waits for init_done.
    task automatic run_init();
        int  k;
        logic early;
        rst = 1'b0;
        exp_q.push_back({1'b0, 4'h3});
        exp_q.push_back({1'b0, 4'h3});
        exp_q.push_back({1'b0, 4'h3});
        exp_q.push_back({1'b0, 4'h2});
        k = 0;
        early = 1'b0;
        while (!init_done && k < 1000) begin
            @(negedge clk);
            k++;
            if (bus.in_ready && !init_done) early = 1'b1;
        end
        check("init_latency", k, INIT_LAT);
        check("ready_before_init", early, 1'b0);
        check("ready_at_init", bus.in_ready, 1'b1);
        check("init_queue_drained", exp_q.size(), 0);
    endtask

    // Presents a byte, waits for its accept edge, then measures how long
    // in_ready stays low. With hold set, in_valid stays high and in_data /
    // in_rs are scrambled while busy; the caller supplies the next byte on
    // the negedge this task returns on.
    task automatic do_byte(input logic rs, input logic [7:0] d, input logic hold);
        int n;
        int k;
        bus.in_valid = 1'b1;
        bus.in_rs    = rs;
        bus.in_data  = d;
        n = 0;
        while (!bus.in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", n < 500, 1'b1);
        @(negedge clk);
        exp_q.push_back({rs, d[7:4]});
        exp_q.push_back({rs, d[3:0]});
        check("ready_drop", bus.in_ready, 1'b0);
        if (!hold) bus.in_valid = 1'b0;
        k = 0;
        while (!bus.in_ready && k < 500) begin
            bus.in_data = 8'($urandom);
            bus.in_rs   = 1'($urandom_range(0, 1));
            @(negedge clk);
            k++;
        end
        check("ready_return", k, 2 * SETUP + 2 * HIGH + GAP + settle_of(rs, d));
        check("byte_drained", exp_q.size(), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       rs;
        logic [7:0] d;
        logic       hold;
        int         n;

        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_rs    = 1'b1;
        bus.in_data  = 8'h48;
        repeat (3) @(negedge clk);
        check_reset_state();

        // in_valid is already high from reset: it must wait for init_done.
        run_init();
        do_byte(1'b1, 8'h48, 1'b0);
        do_byte(1'b0, 8'h01, 1'b0);
        do_byte(1'b1, 8'h65, 1'b1);
        do_byte(1'b1, 8'h6C, 1'b0);

        // Boundaries of the long-settle rule.
        do_byte(1'b0, 8'h00, 1'b0);
        do_byte(1'b0, 8'h02, 1'b1);
        do_byte(1'b0, 8'h03, 1'b1);
        do_byte(1'b0, 8'h04, 1'b0);
        do_byte(1'b1, 8'h01, 1'b0);

        for (int i = 0; i < 16; i++) begin
            rs = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) d = 8'($urandom_range(0, 4));
            else                           d = 8'($urandom);
            hold = (i != 15) && ($urandom_range(0, 1) == 1);
            do_byte(rs, d, hold);
        end
        bus.in_valid = 1'b0;

        // Reset in the middle of a high-nibble pulse.
        repeat (2) @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_rs    = 1'b1;
        bus.in_data  = 8'h5A;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        exp_q.push_back({1'b1, 4'h5});
        exp_q.push_back({1'b1, 4'hA});
        n = 0;
        while (!lcd_e && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("reach_pulse", lcd_e, 1'b1);
        #2;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        check_reset_state();
        exp_q.delete();
        repeat (3) @(negedge clk);
        run_init();

        do_byte(1'b1, 8'h21, 1'b0);
        repeat (5) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        check("final_idle_e", lcd_e, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
